// File: rtl/wb_cmd_master_if.sv
// Command/response and Wishbone classic bus bundle for wb_cmd_master.
// The master modport is the wb_cmd_master view; the slave modport is the command source, response sink and bus slave.
interface wb_cmd_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding command to Wishbone classic master with registered ready/valid response.
// Optional bus timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            active,
    wb_cmd_master_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                // Ready is registered, so it only rises one cycle after entering IDLE.
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = bus.cmd_we_i;
                    sel_d   = bus.cmd_sel_i;
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    cmd_ready_d = active;
                end
            end
            BUS: begin
                if (bus.wbm_ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    {we_d, sel_d, adr_d, dat_d} = '0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? 32'd0 : bus.wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    {we_d, sel_d, adr_d, dat_d} = '0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    cnt_d       = cnt_q + 16'd1;
                end else begin
                    cnt_d       = cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    assign bus.rsp_err_o   = rsp_err_q;
`else
    assign bus.rsp_err_o   = 1'b0;
`endif
    // Single-transfer classic cycles: strobe always mirrors cycle.
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed table, random transactions, timeout/reset sequences.
module tb_wb_cmd_master;
    localparam int unsigned TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic active = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    wb_cmd_master_if bus_if ();

    wb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .active   (active),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          ack_at;
        int          bp;
        logic        drop_act;
        logic [31:0] exp_dat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input string tag);
        int g = 0;
        while (bus_if.cmd_ready_o !== 1'b1 && g < 20) begin tick(); g++; end
        chk({tag, " cmd_ready"}, 32'(bus_if.cmd_ready_o), 32'd1);
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = we;
        bus_if.cmd_adr_i   = adr;
        bus_if.cmd_dat_i   = dat;
        bus_if.cmd_sel_i   = sel;
        tick();
        // scramble the command so the DUT must have latched it
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_we_i    = 1'($urandom);
        bus_if.cmd_adr_i   = $urandom;
        bus_if.cmd_dat_i   = $urandom;
        bus_if.cmd_sel_i   = 4'($urandom);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n_cyc  = 0;
        bit stable = 1'b1;
        bit quiet  = 1'b1;
        bit held   = 1'b1;
        issue(v.we, v.adr, v.dat, v.sel, tag);
        while (bus_if.wbm_cyc_o === 1'b1 && n_cyc < 50) begin
            n_cyc++;
            if (bus_if.wbm_stb_o !== 1'b1 || bus_if.wbm_adr_o !== v.adr || bus_if.wbm_dat_o !== v.dat ||
                bus_if.wbm_sel_o !== v.sel || bus_if.wbm_we_o !== v.we || bus_if.cmd_ready_o !== 1'b0)
                stable = 1'b0;
            if (bus_if.rsp_valid_o !== 1'b0) quiet = 1'b0;
            if (n_cyc == v.ack_at) begin
                bus_if.wbm_ack_i = 1'b1;
                bus_if.wbm_dat_i = v.rdata;
            end else begin
                bus_if.wbm_ack_i = 1'b0;
                bus_if.wbm_dat_i = $urandom;
            end
            if (v.drop_act) active = 1'b0;
            tick();
        end
        bus_if.wbm_ack_i = 1'b0;
        chk({tag, " cyc cycles"}, 32'(n_cyc), 32'(v.ack_at));
        chk({tag, " bus fields"}, 32'(stable), 32'd1);
        chk({tag, " no early rsp"}, 32'(quiet), 32'd1);
        chk({tag, " rsp_valid"}, 32'(bus_if.rsp_valid_o), 32'd1);
        chk({tag, " rsp_dat"}, bus_if.rsp_dat_o, v.exp_dat);
        chk({tag, " rsp_err"}, 32'(bus_if.rsp_err_o), 32'd0);
        for (int i = 0; i < v.bp; i++) begin
            bus_if.wbm_ack_i = 1'($urandom);
            tick();
            if (bus_if.rsp_valid_o !== 1'b1 || bus_if.rsp_dat_o !== v.exp_dat || bus_if.rsp_err_o !== 1'b0 ||
                bus_if.cmd_ready_o !== 1'b0 || bus_if.wbm_cyc_o !== 1'b0)
                held = 1'b0;
        end
        chk({tag, " rsp held"}, 32'(held), 32'd1);
        bus_if.wbm_ack_i   = 1'b1;
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        chk({tag, " rsp_valid drop"}, 32'(bus_if.rsp_valid_o), 32'd0);
        chk({tag, " idle gap ready"}, 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        bus_if.wbm_ack_i = 1'b0;
        chk({tag, " stray ack"}, 32'(bus_if.wbm_cyc_o), 32'd0);
        chk({tag, " ready after gap"}, 32'(bus_if.cmd_ready_o), 32'(!v.drop_act));
        active = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        int   n;
        bit   ok;
        tbl[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 32'h1234_5678, 3, 0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1, 0, 1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 32'h3000_0010, 32'h5555_AAAA, 4'h3, 32'hCAFE_0001, 2, 5, 1'b0, 32'hCAFE_0001};
        tbl[3] = '{1'b1, 32'h3000_00FC, 32'h0F0F_0F0F, 4'h1, 32'hFFFF_FFFF, 4, 1, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 32'h3000_0020, 32'h0000_0001, 4'hC, 32'h0BAD_F00D, 2, 2, 1'b1, 32'h0BAD_F00D};

        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_we_i    = 1'b0;
        bus_if.cmd_adr_i   = '0;
        bus_if.cmd_dat_i   = '0;
        bus_if.cmd_sel_i   = '0;
        bus_if.rsp_ready_i = 1'b0;
        bus_if.wbm_dat_i   = '0;
        bus_if.wbm_ack_i   = 1'b0;

        #12;
        chk("reset outputs", {bus_if.rsp_dat_o, 24'd0}, 32'd0);
        chk("reset ctrl", 32'({bus_if.wbm_cyc_o, bus_if.wbm_stb_o, bus_if.wbm_we_o, bus_if.cmd_ready_o,
                               bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.wbm_sel_o}), 32'd0);
        chk("reset adr/dat", bus_if.wbm_adr_o | bus_if.wbm_dat_o, 32'd0);
        active = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready before first edge", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        chk("ready first edge", 32'(bus_if.cmd_ready_o), 32'd1);

        for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            v.we       = 1'($urandom);
            v.adr      = $urandom;
            v.dat      = $urandom;
            v.sel      = 4'($urandom);
            v.rdata    = $urandom;
            v.ack_at   = $urandom_range(1, TO);
            v.bp       = $urandom_range(0, 3);
            v.drop_act = 1'b0;
            v.exp_dat  = v.we ? 32'd0 : v.rdata;
            run_txn(v, $sformatf("rand%0d", i));
        end

        active = 1'b0;
        tick();
        bus_if.cmd_valid_i = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (bus_if.cmd_ready_o !== 1'b0 || bus_if.wbm_cyc_o !== 1'b0) ok = 1'b0;
        end
        chk("inactive blocks cmd", 32'(ok), 32'd1);
        bus_if.cmd_valid_i = 1'b0;
        active = 1'b1;
        tick();

        bus_if.wbm_dat_i = 32'h1357_9BDF;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        issue(1'b0, 32'h3000_0040, 32'd0, 4'hF, "timeout");
        n = 0;
        while (bus_if.wbm_cyc_o === 1'b1 && n < 50) begin n++; tick(); end
        chk("timeout cyc cycles", 32'(n), 32'(TO));
        chk("timeout rsp_valid", 32'(bus_if.rsp_valid_o), 32'd1);
        chk("timeout rsp_err", 32'(bus_if.rsp_err_o), 32'd1);
        chk("timeout rsp_dat", bus_if.rsp_dat_o, 32'd0);
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        tick();
        issue(1'b1, 32'h3000_0044, 32'h2222_3333, 4'hF, "rst");
        tick();
`else
        issue(1'b0, 32'h3000_0040, 32'd0, 4'hF, "hang");
        n = 0;
        repeat (1000) begin
            if (bus_if.wbm_cyc_o === 1'b1 && bus_if.rsp_valid_o === 1'b0) n++;
            tick();
        end
        chk("no timeout cyc held", 32'(n), 32'd1000);
        chk("no timeout rsp_err", 32'(bus_if.rsp_err_o), 32'd0);
`endif
        chk("cyc before reset", 32'(bus_if.wbm_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset mid-bus", 32'({bus_if.wbm_cyc_o, bus_if.wbm_stb_o, bus_if.cmd_ready_o,
                                        bus_if.rsp_valid_o}), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready after release", 32'(bus_if.cmd_ready_o), 32'd0);
        tick();
        chk("ready first edge 2", 32'(bus_if.cmd_ready_o), 32'd1);
        chk("cyc idle after reset", 32'(bus_if.wbm_cyc_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max wait for wbm_ack_i in BUS; legal range 1..65535.
REQ-002 wb_clk_i  input  1  sole clock; all flops rising-edge.
REQ-003 wb_rst_ni  input  1  asynchronous active-low reset.
REQ-004 active  input  1  project select; gates acceptance of new commands.
REQ-005 cmd_valid_i  input  1  command offered.
REQ-006 cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high at a clock edge.
REQ-007 cmd_we_i  input  1  1 = write, 0 = read.
REQ-008 cmd_adr_i  input  32  byte address.
REQ-009 cmd_dat_i  input  32  write data.
REQ-010 cmd_sel_i  input  4  byte lane select.
REQ-011 rsp_valid_o  output  1  response available.
REQ-012 rsp_ready_i  input  1  response consumed when rsp_valid_o and rsp_ready_i are both high.
REQ-013 rsp_dat_o  output  32  read data (0 for writes and errors).
REQ-014 rsp_err_o  output  1  transaction timed out.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-016 wbm_sel_o  output  4; wbm_adr_o  output  32; wbm_dat_o  output  32  Wishbone master request fields.
REQ-017 wbm_dat_i  input  32; wbm_ack_i  input  1  Wishbone slave response.

Function
REQ-018 FSM states SHALL be IDLE, BUS and RESP, and no others.
REQ-019 IDLE: cmd_ready_o = active; all other outputs hold reset values except rsp_dat_o/rsp_err_o, which may hold stale values.
REQ-020 Accept in IDLE: command latched into wbm_* registers; BUS entered next cycle with wbm_cyc_o = wbm_stb_o = 1; timeout counter cleared.
REQ-021 BUS: cmd_ready_o = 0; wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o SHALL be stable until exit; the counter increments by 1 each cycle without ack.
REQ-022 wbm_ack_i high in BUS: next cycle wbm_cyc_o = wbm_stb_o = 0; rsp_dat_o = wbm_dat_i for a read, else 0; rsp_err_o = 0; state goes to RESP with rsp_valid_o = 1.
REQ-023 Minimum command-to-response latency: ack in the first BUS cycle, rsp_valid_o high two cycles after acceptance.
REQ-024 wbm_ack_i SHALL be ignored in IDLE and RESP.
REQ-025 RESP: rsp_valid_o, rsp_dat_o and rsp_err_o held until handshake; then IDLE next cycle with rsp_valid_o = 0.
REQ-026 A new command is never accepted in the handshake cycle of a response; one idle cycle minimum between transactions.
REQ-027 active falling during BUS or RESP: the current transaction completes normally; acceptance is blocked thereafter.
REQ-028 wbm_dat_o is driven for reads as latched but is don't-care to the slave.

Reset
REQ-029 Reset assertion SHALL asynchronously force IDLE, counter = 0 and every output to 0, including in mid-BUS (cyc/stb drop immediately).
REQ-030 Outputs leave reset values only on the first clock edge after wb_rst_ni deasserts.

Configuration
REQ-031 Macro WB_CMD_MASTER_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES in BUS without ack, the next cycle drops wbm_cyc_o/wbm_stb_o, sets rsp_err_o = 1 and rsp_dat_o = 0, and enters RESP.
REQ-032 Ack and timeout in the same cycle: ack wins (rsp_err_o = 0).
REQ-033 Macro undefined: no counter logic; BUS waits indefinitely for ack; rsp_err_o tied 0.

Verification
REQ-034 Write: active=1, cmd adr=0x30000004, dat=0xA5A5_0001, sel=0xF, we=1; slave acks on 3rd BUS cycle -> cyc/stb high exactly 3 cycles, wbm_dat_o=0xA5A50001, rsp_valid_o with rsp_dat_o=0, rsp_err_o=0.
REQ-035 Read: slave returns 0xDEADBEEF with ack in 1st BUS cycle -> rsp_valid_o 2 cycles after accept, rsp_dat_o=0xDEADBEEF.
REQ-036 Backpressure: rsp_ready_i low 5 cycles -> rsp_* held, cmd_ready_o=0 throughout; one idle cycle after handshake, then cmd_ready_o=1.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=4, no ack) -> cyc/stb drop after 4 counted cycles, rsp_err_o=1, rsp_dat_o=0; with macro undefined, cyc stays high 1000 cycles.
REQ-038 Reset mid-BUS: wb_rst_ni low between edges -> cyc/stb/cmd_ready_o low immediately; after release, cmd_ready_o=1 on the first edge with active=1.
REQ-039 active=0 with cmd_valid_i=1 for 10 cycles -> cmd_ready_o=0, no bus cycle issued.
